bp_be_int_rebox_pipe: RTL and testbench
=======================================

Name: bp_be_int_rebox_pipe

Overview:
- Pipelined, multi-lane integer box/unbox unit for the BE calculator.
- Each lane either unboxes a tagged integer register (tag + 64-bit value) into a plain dword under a target width and signedness, or boxes a dword into a tagged register.
- Valid/ready elastic pipeline with configurable depth; records invalid-box events in a sticky flag and a saturating counter readable by the CSR path.

Parameters:
- lanes_p, 2, number of independent lanes sharing one handshake.
- stages_p, 2, pipeline depth (latency in cycles); legal range 1..4.
- dword_width_p, 64, value width.
- reg_width_p, 66, tagged register width; format is {tag[1:0], val[63:0]}.
- cnt_width_p, 16, invalid-box counter width.

Ports:
- clk_i, input, 1, clock.
- reset_n_i, input, 1, asynchronous active-low reset.
- v_i, input, 1, request valid.
- ready_and_o, output, 1, unit can accept a request this cycle.
- box_i, input, 1, 1 = box mode, 0 = unbox mode; applies to all lanes.
- reg_i, input, lanes_p*reg_width_p, per-lane tagged register (unbox) or {don't-care tag, value} (box).
- tag_i, input, lanes_p*2, per-lane target tag: 0 byte, 1 hword, 2 word, 3 dword.
- unsigned_i, input, lanes_p, per-lane zero-extend select.
- v_o, output, 1, result valid.
- ready_and_i, input, 1, downstream accepts the result.
- data_o, output, lanes_p*reg_width_p, per-lane result.
- invbox_o, output, lanes_p, per-lane flag: target tag > source tag (unbox mode only).
- invbox_sticky_o, output, 1, OR of all invbox_o seen since the last clear.
- invbox_cnt_o, output, cnt_width_p, saturating count of lane invbox events.
- clr_i, input, 1, synchronous clear of the sticky flag and counter.

Behaviour:
- Reset (asynchronous, reset_n_i=0): all stage valids 0, so v_o=0.
- Also on reset: invbox_sticky_o=0, invbox_cnt_o=0, data_o=0, invbox_o=0, and ready_and_o=1 once reset deasserts.
- Handshake: a request is accepted when v_i & ready_and_o. A result retires when v_o & ready_and_i.
- Stage k advances when it is empty or stage k+1 advances. The final stage advances when it is empty or ready_and_i=1.
- ready_and_o = stage-0 advance condition; it is combinational from ready_and_i and the stage valids.
- Latency is exactly stages_p cycles with no backpressure. Back-to-back accepts give one result per cycle.
- Under backpressure, data_o and invbox_o hold stable while v_o=1. No request is dropped or duplicated.
- Compute happens in stage 0; later stages only register it.
- Unbox, per lane, with s = reg tag, t = tag_i, v = reg value:
  - raw = v[0 +: width(s)] with all bits above width(s) filled with v[63]; for s = dword, raw = v.
  - invbox = (t > s).
  - If unsigned: result = zero-extend raw[0 +: width(t)].
  - Else if invbox: result = sign-extend raw[0 +: width(t)].
  - Else: result = raw.
  - data_o lane = {2'd3, result}.
- Box, per lane, with t = tag_i and v = reg_i[63:0]:
  - val = v[0 +: width(t)], sign-extended (zero-extended if unsigned) to 64 bits.
  - data_o lane = {t, val}.
  - invbox forced to 0.
- Widths: byte = 8, hword = 16, word = 32, dword = 64.
- Event accounting on each accept:
  - The counter adds popcount(invbox) of the accepted lanes, saturating at all-ones.
  - The sticky flag is set if any lane's invbox is set.
- clr_i in the same cycle as an accept: the clear wins, then that cycle's increment applies. Result: counter = popcount, sticky = any invbox.
- Reset mid-operation flushes all in-flight requests; nothing is retired.

Test Plan:
- Unbox, lanes_p=2, stages_p=2, all handshakes open:
  - Lane 0: reg {0, 64'h0000_0000_0000_0080}, t=0, signed -> data {3, 64'h0000_0000_0000_0080}; not invbox, raw has v[63]=0 above the byte.
  - Lane 1: same reg, t=1, signed -> invbox_o[1]=1, data {3, 64'h0000_0000_0000_0080}; appears at cycle 2.
- Unbox with reg {0, 64'h8000_0000_0000_00F0}:
  - t=2, signed -> 64'hFFFF_FFFF_FFFF_FFF0, invbox=1.
  - t=2, unsigned -> 64'h0000_0000_FFFF_FFF0.
- Box with v=64'h1234_5678_9ABC_DEF0:
  - t=1, signed -> data {1, 64'hFFFF_FFFF_FFFF_DEF0}.
  - t=1, unsigned -> {1, 64'h0000_0000_0000_DEF0}.
  - invbox_o=0.
- Backpressure:
  - Stream 6 requests, hold ready_and_i=0 for 3 cycles mid-stream -> ready_and_o falls once both stages are full.
  - data_o stays stable while stalled.
  - All 6 results come out in order, with no loss or duplication.
- Counter:
  - Set cnt_width_p=2 and drive 3 accepts each with 2 invbox lanes -> counter saturates at 3 and sticky=1.
  - Then clr_i with a 1-invbox accept in the same cycle -> counter=1, sticky=1.
- Async reset asserted with 2 requests in flight -> v_o=0 immediately, counter=0, and no result after release.

Source files
------------

// File: rtl/bp_be_int_rebox_pipe.sv
// Multi-lane integer box/unbox unit. The result is computed as a request enters,
// then carried through an elastic valid/ready pipeline of stages_p registers.
module bp_be_int_rebox_pipe
  #(parameter int lanes_p       = 2
  , parameter int stages_p      = 2
  , parameter int dword_width_p = 64
  , parameter int reg_width_p   = 66
  , parameter int cnt_width_p   = 16
  )
  (input  logic                             clk_i
  , input  logic                            reset_n_i
  , input  logic                            v_i
  , output logic                            ready_and_o
  , input  logic                            box_i
  , input  logic [lanes_p*reg_width_p-1:0]  reg_i
  , input  logic [lanes_p*2-1:0]            tag_i
  , input  logic [lanes_p-1:0]              unsigned_i
  , output logic                            v_o
  , input  logic                            ready_and_i
  , output logic [lanes_p*reg_width_p-1:0]  data_o
  , output logic [lanes_p-1:0]              invbox_o
  , output logic                            invbox_sticky_o
  , output logic [cnt_width_p-1:0]          invbox_cnt_o
  , input  logic                            clr_i
  );

    localparam int data_width_lp = lanes_p*reg_width_p;
    localparam int pop_width_lp  = $clog2(lanes_p+1);
    localparam int sum_width_lp  = cnt_width_p + pop_width_lp;

    function automatic logic [63:0] mask_f(input logic [1:0] t);
        case (t)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] ext_f(input logic [63:0] v, input logic [1:0] t, input logic sgn);
        logic msb;
        case (t)
            2'd0:    msb = v[7];
            2'd1:    msb = v[15];
            2'd2:    msb = v[31];
            default: msb = v[63];
        endcase
        return (v & mask_f(t)) | ((sgn & msb) ? ~mask_f(t) : 64'h0);
    endfunction

    logic [data_width_lp-1:0] comp_data_s;
    logic [lanes_p-1:0]       comp_inv_s;

    for (genvar l = 0; l < lanes_p; l++) begin : lane
        logic [dword_width_p-1:0] val_s, raw_s, res_s;
        logic [1:0]               src_tag_s, tgt_tag_s;
        logic                     inv_s;

        assign val_s     = reg_i[l*reg_width_p +: dword_width_p];
        assign src_tag_s = reg_i[l*reg_width_p+dword_width_p +: 2];
        assign tgt_tag_s = tag_i[l*2 +: 2];
        // Unbox fills above the source width with the stored value's top bit, not the field's msb.
        assign raw_s = (val_s & mask_f(src_tag_s))
                     | ({dword_width_p{val_s[dword_width_p-1]}} & ~mask_f(src_tag_s));

        // Per-lane box/unbox result
        always_comb begin
            inv_s = 1'b0;
            res_s = raw_s;
            if (box_i) begin
                inv_s = 1'b0;
                res_s = ext_f(val_s, tgt_tag_s, ~unsigned_i[l]);
            end else begin
                inv_s = (tgt_tag_s > src_tag_s);
                if (unsigned_i[l]) begin
                    res_s = ext_f(raw_s, tgt_tag_s, 1'b0);
                end else if (inv_s) begin
                    res_s = ext_f(raw_s, tgt_tag_s, 1'b1);
                end else begin
                    res_s = raw_s;
                end
            end
        end

        assign comp_data_s[l*reg_width_p +: reg_width_p] = {(box_i ? tgt_tag_s : 2'd3), res_s};
        assign comp_inv_s[l] = inv_s;
    end

    logic [stages_p-1:0]      valid_q;
    logic [data_width_lp-1:0] data_q [stages_p];
    logic [lanes_p-1:0]       inv_q  [stages_p];
    logic [stages_p-1:0]      adv_s;

    // A stage may advance when ready_and_i is high or any stage at or after it is empty
    always_comb begin : adv_calc
        logic all_full;
        all_full = 1'b1;
        for (int k = stages_p-1; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            adv_s[k] = ready_and_i | ~all_full;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            for (int k = 0; k < stages_p; k++) begin
                data_q[k] <= '0;
                inv_q[k]  <= '0;
            end
        end else begin
            if (adv_s[0]) begin
                valid_q[0] <= v_i;
                data_q[0]  <= comp_data_s;
                inv_q[0]   <= comp_inv_s;
            end
            for (int k = 1; k < stages_p; k++) begin
                if (adv_s[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    data_q[k]  <= data_q[k-1];
                    inv_q[k]   <= inv_q[k-1];
                end
            end
        end
    end

    logic                     accept_s;
    logic [pop_width_lp-1:0]  pop_s;
    logic [cnt_width_p-1:0]   base_s, cnt_d, cnt_q;
    logic [sum_width_lp-1:0]  sum_s;
    logic                     sticky_d, sticky_q;

    assign accept_s = v_i & ready_and_o;

    // Invalid-box accounting; a same-cycle clear is applied before the increment
    always_comb begin
        pop_s = '0;
        for (int l = 0; l < lanes_p; l++) begin
            pop_s = pop_s + pop_width_lp'(comp_inv_s[l]);
        end
        base_s = clr_i ? {cnt_width_p{1'b0}} : cnt_q;
        sum_s  = {{pop_width_lp{1'b0}}, base_s} + {{cnt_width_p{1'b0}}, pop_s};
        if (accept_s) begin
            if (|sum_s[sum_width_lp-1:cnt_width_p]) begin
                cnt_d = {cnt_width_p{1'b1}};
            end else begin
                cnt_d = sum_s[cnt_width_p-1:0];
            end
        end else begin
            cnt_d = base_s;
        end
        sticky_d = (clr_i ? 1'b0 : sticky_q) | (accept_s & |comp_inv_s);
    end

    // Accounting registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign ready_and_o     = adv_s[0];
    assign v_o             = valid_q[stages_p-1];
    assign data_o          = data_q[stages_p-1];
    assign invbox_o        = inv_q[stages_p-1];
    assign invbox_cnt_o    = cnt_q;
    assign invbox_sticky_o = sticky_q;

endmodule

// File: tb/tb_bp_be_int_rebox_pipe.sv
// Directed bench for bp_be_int_rebox_pipe: an arithmetic reference model with a
// per-cycle result scoreboard, plus hand-computed literal checks.
module tb_bp_be_int_rebox_pipe;

    localparam int L  = 2;
    localparam int S  = 2;
    localparam int RW = 66;
    localparam int CW = 2;
    localparam int DW = L*RW;

    logic            clk, reset_n_i, v_i, ready_and_o, box_i, v_o, ready_and_i, clr_i;
    logic [DW-1:0]   reg_i, data_o;
    logic [L*2-1:0]  tag_i;
    logic [L-1:0]    unsigned_i, invbox_o;
    logic            invbox_sticky_o;
    logic [CW-1:0]   invbox_cnt_o;

    bp_be_int_rebox_pipe #(.lanes_p(L), .stages_p(S), .dword_width_p(64),
                           .reg_width_p(RW), .cnt_width_p(CW)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_and_o(ready_and_o),
        .box_i(box_i), .reg_i(reg_i), .tag_i(tag_i), .unsigned_i(unsigned_i),
        .v_o(v_o), .ready_and_i(ready_and_i), .data_o(data_o), .invbox_o(invbox_o),
        .invbox_sticky_o(invbox_sticky_o), .invbox_cnt_o(invbox_cnt_o), .clr_i(clr_i));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_ret    = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: keep the low w bits, then extend
    function automatic logic [63:0] fit(input logic [63:0] v, input int w, input bit sgn);
        logic [63:0] lo;
        if (w == 64) return v;
        lo = v % (64'd1 << w);
        if (sgn && lo >= (64'd1 << (w-1))) return lo - (64'd1 << w);
        return lo;
    endfunction

    task automatic model(input logic box, input logic [DW-1:0] r, input logic [L*2-1:0] t,
                         input logic [L-1:0] u, output logic [DW-1:0] d, output logic [L-1:0] inv);
        for (int l = 0; l < L; l++) begin
            logic [63:0] v, raw, res;
            int s, tt, ws, wt;
            v  = r[l*RW +: 64];
            s  = int'(r[l*RW+64 +: 2]);
            tt = int'(t[l*2 +: 2]);
            ws = 8 << s;
            wt = 8 << tt;
            if (box) begin
                inv[l] = 1'b0;
                res = fit(v, wt, !u[l]);
                d[l*RW +: RW] = {t[l*2 +: 2], res};
            end else begin
                raw = fit(v, ws, 1'b0);
                if (ws < 64 && v[63]) raw = raw + (64'd0 - (64'd1 << ws));
                inv[l] = (tt > s);
                if (u[l])        res = fit(raw, wt, 1'b0);
                else if (inv[l]) res = fit(raw, wt, 1'b1);
                else             res = raw;
                d[l*RW +: RW] = {2'd3, res};
            end
        end
    endtask

    logic [DW-1:0] exp_d[$];
    logic [L-1:0]  exp_i[$];
    int            cnt_m = 0;
    logic          st_m = 1'b0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic [L-1:0]  hold_i;

    // Scoreboard: checks every cycle, then books the request accepted at the coming edge
    always @(negedge clk) begin
        if (reset_n_i) begin
            logic [DW-1:0] d;
            logic [L-1:0]  inv;
            chk("invbox_cnt", invbox_cnt_o, cnt_m);
            chk("invbox_sticky", invbox_sticky_o, st_m);
            if (v_o) begin
                if (hold_v) begin
                    chk("stall_data_hold", data_o, hold_d);
                    chk("stall_inv_hold", invbox_o, hold_i);
                end
                if (ready_and_i) begin
                    if (exp_d.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL extra_result: got %h expected none", data_o);
                    end else begin
                        chk("result_data", data_o, exp_d.pop_front());
                        chk("result_inv", invbox_o, exp_i.pop_front());
                        n_ret++;
                    end
                end
            end
            hold_v = v_o && !ready_and_i;
            hold_d = data_o;
            hold_i = invbox_o;
            if (clr_i) begin
                cnt_m = 0;
                st_m  = 1'b0;
            end
            if (v_i && ready_and_o) begin
                model(box_i, reg_i, tag_i, unsigned_i, d, inv);
                exp_d.push_back(d);
                exp_i.push_back(inv);
                cnt_m = cnt_m + $countones(inv);
                if (cnt_m > 3) cnt_m = 3;
                st_m = st_m | (|inv);
            end
        end
    end

    task automatic send_req(input logic box, input logic [65:0] r0, input logic [65:0] r1,
                            input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] u);
        bit ok;
        box_i = box; reg_i = {r1, r0}; tag_i = {t1, t0}; unsigned_i = u; v_i = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ready_and_o) ok = 1;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got ready_and_o=0 expected 1");
        end
        @(posedge clk);
        #1 v_i = 1'b0;
    endtask

    task automatic directed(input string nm, input logic box, input logic [65:0] r0, input logic [65:0] r1,
                            input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] u,
                            input logic [DW-1:0] ed, input logic [L-1:0] ei);
        send_req(box, r0, r1, t0, t1, u);
        @(negedge clk);
        chk({nm, "_v_early"}, v_o, 1'b0);
        @(negedge clk);
        chk({nm, "_v"}, v_o, 1'b1);
        chk({nm, "_data"}, data_o, ed);
        chk({nm, "_inv"}, invbox_o, ei);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int ret0;
        clk = 1'b0; reset_n_i = 1'b0; v_i = 1'b0; box_i = 1'b0; reg_i = '0; tag_i = '0;
        unsigned_i = '0; ready_and_i = 1'b1; clr_i = 1'b0;
        #12;
        chk("rst_v", v_o, 1'b0);
        chk("rst_data", data_o, '0);
        chk("rst_inv", invbox_o, '0);
        chk("rst_cnt", invbox_cnt_o, '0);
        chk("rst_sticky", invbox_sticky_o, 1'b0);
        @(posedge clk);
        #1 reset_n_i = 1'b1;
        #1 chk("rst_ready", ready_and_o, 1'b1);

        directed("unbox_byte", 1'b0, {2'd0, 64'h80}, {2'd0, 64'h80}, 2'd0, 2'd1, 2'b00,
                 {2'd3, 64'h0000_0000_0000_0080, 2'd3, 64'h0000_0000_0000_0080}, 2'b10);
        directed("unbox_word", 1'b0, {2'd0, 64'h8000_0000_0000_00F0}, {2'd0, 64'h8000_0000_0000_00F0},
                 2'd2, 2'd2, 2'b10,
                 {2'd3, 64'h0000_0000_FFFF_FFF0, 2'd3, 64'hFFFF_FFFF_FFFF_FFF0}, 2'b11);
        directed("box_hword", 1'b1, {2'd0, 64'h1234_5678_9ABC_DEF0}, {2'd2, 64'h1234_5678_9ABC_DEF0},
                 2'd1, 2'd1, 2'b10,
                 {2'd1, 64'h0000_0000_0000_DEF0, 2'd1, 64'hFFFF_FFFF_FFFF_DEF0}, 2'b00);

        // Backpressure: six requests with a three-cycle stall in the middle
        ret0 = n_ret;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [65:0] a, b;
                    a = {2'($urandom_range(0, 3)), $urandom, $urandom};
                    b = {2'($urandom_range(0, 3)), $urandom, $urandom};
                    send_req(1'(i % 2), a, b, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                             2'($urandom_range(0, 3)));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 ready_and_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready_low", ready_and_o, 1'b0);
                    chk("stall_v_high", v_o, 1'b1);
                end
                @(posedge clk);
                #1 ready_and_i = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_retired", n_ret - ret0, 6);
        chk("bp_drained", exp_d.size(), 0);

        // Counter saturation and clear-with-accept
        clr_i = 1'b1;
        @(posedge clk);
        #1 clr_i = 1'b0;
        @(negedge clk);
        chk("clr_cnt", invbox_cnt_o, 2'd0);
        chk("clr_sticky", invbox_sticky_o, 1'b0);
        @(posedge clk);
        #1;
        repeat (3) send_req(1'b0, {2'd0, 64'h5}, {2'd1, 64'h7}, 2'd1, 2'd3, 2'b00);
        @(negedge clk);
        chk("sat_cnt", invbox_cnt_o, 2'd3);
        chk("sat_sticky", invbox_sticky_o, 1'b1);
        @(posedge clk);
        #1 clr_i = 1'b1;
        send_req(1'b0, {2'd0, 64'h5}, {2'd1, 64'h7}, 2'd1, 2'd0, 2'b00);
        clr_i = 1'b0;
        @(negedge clk);
        chk("clracc_cnt", invbox_cnt_o, 2'd1);
        chk("clracc_sticky", invbox_sticky_o, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset with two requests in flight
        send_req(1'b0, {2'd0, 64'h1}, {2'd0, 64'h2}, 2'd3, 2'd3, 2'b00);
        send_req(1'b0, {2'd1, 64'h3}, {2'd0, 64'h4}, 2'd2, 2'd2, 2'b00);
        #1 reset_n_i = 1'b0;
        #1;
        chk("arst_v", v_o, 1'b0);
        chk("arst_cnt", invbox_cnt_o, '0);
        chk("arst_sticky", invbox_sticky_o, 1'b0);
        chk("arst_data", data_o, '0);
        exp_d.delete();
        exp_i.delete();
        cnt_m = 0;
        st_m = 1'b0;
        hold_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("arst_no_result", v_o, 1'b0);
        end
        chk("arst_ready", ready_and_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
